// File: rtl/shared_ram_arbiter.sv
// Round-robin arbiter in front of a shared write-once RAM with per-location used flags.
// Define RAM_REDIRECT_EN to redirect writes aimed at used locations to the next free address.
module shared_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int NUM_PORTS  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]           rsp_addr,
  output logic [1:0]                      rsp_status,
  input  logic                            clear_all,
  output logic [ADDR_WIDTH:0]             free_count,
  output logic                            full
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [1:0] ST_OK = 2'b00, ST_REDIR = 2'b01, ST_REJ = 2'b10, ST_EMPTY = 2'b11;

`ifdef RAM_REDIRECT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, SCAN = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd3} state_t;
`endif

  state_t state_q, state_d;

  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_v;
  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      used_q;
  logic [PW-1:0]         rr_q, cap_port, gnt_idx, cand;
  logic                  cap_write, gnt_vld, hs;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;

  logic                  mem_we, rsp_load;
  logic [ADDR_WIDTH-1:0] mem_waddr, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_d;
  logic [1:0]            rsp_st_d;
`ifdef RAM_REDIRECT_EN
  logic [ADDR_WIDTH-1:0] scan_q, scan_d;
`endif

  assign full = (free_count == '0);

  // Walk ports downward so the last hit is the first valid port after rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    cand    = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = PW'((int'(rr_q) + i) % NUM_PORTS);
      if (req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    hs         = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cap_addr;
    rsp_load   = 1'b0;
    rsp_st_d   = ST_OK;
    rsp_addr_d = cap_addr;
    rsp_data_d = '0;
`ifdef RAM_REDIRECT_EN
    scan_d     = scan_q;
`endif
    case (state_q)
      IDLE: begin
        if (!clear_all && gnt_vld) begin
          req_ready[gnt_idx] = 1'b1;
          hs                 = 1'b1;
          state_d            = ACCESS;
        end
      end
      ACCESS: begin
        rsp_load = 1'b1;
        state_d  = RESP;
        if (!cap_write) begin
          rsp_data_d = used_q[cap_addr] ? mem[cap_addr] : '0;
          rsp_st_d   = used_q[cap_addr] ? ST_OK : ST_EMPTY;
        end else if (!used_q[cap_addr]) begin
          mem_we = 1'b1;
        end else begin
`ifdef RAM_REDIRECT_EN
          if (full) begin
            rsp_st_d = ST_REJ;
          end else begin
            rsp_load = 1'b0;
            scan_d   = cap_addr + 1'b1;
            state_d  = SCAN;
          end
`else
          rsp_st_d = ST_REJ;
`endif
        end
      end
`ifdef RAM_REDIRECT_EN
      // A free slot exists whenever we get here, so the walk always ends.
      SCAN: begin
        if (!used_q[scan_q]) begin
          mem_we     = 1'b1;
          mem_waddr  = scan_q;
          rsp_addr_d = scan_q;
          rsp_st_d   = ST_REDIR;
          rsp_load   = 1'b1;
          state_d    = RESP;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q     <= '0;
      free_count <= DEPTH_CNT;
      rr_q       <= PW'(NUM_PORTS - 1);
      cap_port   <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_addr   <= '0;
      rsp_status <= ST_OK;
`ifdef RAM_REDIRECT_EN
      scan_q     <= '0;
`endif
    end else begin
`ifdef RAM_REDIRECT_EN
      scan_q <= scan_d;
`endif
      if (state_q == IDLE && clear_all) begin
        used_q     <= '0;
        free_count <= DEPTH_CNT;
      end
      if (hs) begin
        cap_port  <= gnt_idx;
        cap_write <= req_write[gnt_idx];
        cap_addr  <= addr_v[gnt_idx];
        cap_wdata <= wdata_v[gnt_idx];
        rr_q      <= gnt_idx;
      end
      if (mem_we) begin
        used_q[mem_waddr] <= 1'b1;
        if (free_count != '0) free_count <= free_count - 1'b1;
      end
      rsp_valid <= '0;
      if (rsp_load) begin
        rsp_valid[cap_port] <= 1'b1;
        rsp_data            <= rsp_data_d;
        rsp_addr            <= rsp_addr_d;
        rsp_status          <= rsp_st_d;
      end
    end
  end

  // Storage is not reset; the write is dropped if reset lands on the same edge.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= cap_wdata;
  end

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter; expectations follow RAM_REDIRECT_EN when defined.
module tb_shared_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [15:0] req_addr, req_wdata;
  logic [7:0]  rsp_data, rsp_addr;
  logic [1:0]  rsp_status;
  logic        clear_all, full;
  logic [8:0]  free_count;

  int checks = 0;
  int errors = 0;

  shared_ram_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .rsp_status(rsp_status), .clear_all(clear_all), .free_count(free_count),
    .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on port p; returns the response fields and negedges from accept to response.
  task automatic txn(input int p, input bit w, input logic [7:0] a, input logic [7:0] d,
                     output logic [1:0] st, output logic [7:0] ra, output logic [7:0] rd,
                     output int lat);
    bit acc = 0;
    int n;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_write[p] = w;
    req_addr[p*8 +: 8]  = a;
    req_wdata[p*8 +: 8] = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      if (req_ready[p]) acc = 1;
      else @(negedge clk);
    end
    if (!acc) chk("accept timeout", 0, 1);
    @(negedge clk);
    req_valid[p] = 1'b0;
    n = 1;
    while (!rsp_valid[p] && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid[p]) chk("response timeout", 0, 1);
    st = rsp_status; ra = rsp_addr; rd = rsp_data; lat = n;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear_all = 1'b1;
    @(negedge clk);
    clear_all = 1'b0;
  endtask

  logic [1:0] st;
  logic [7:0] ra, rd;
  int lat;

  initial begin
    int gseq[4], gcyc[4];
    int ng, nr, pport;
    bit pend, quiet;
    logic [7:0] a0, a1, tgt;

    rst = 1'b1; clear_all = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_addr", rsp_addr, 0);
    chk("rst rsp_status", rsp_status, 0);
    chk("rst free_count", free_count, 256);
    chk("rst full", full, 0);
    rst = 1'b0;

    // basic write then read across ports
    txn(0, 1, 8'h05, 8'h10, st, ra, rd, lat);
    chk("t1 wr status", st, 0);
    chk("t1 wr addr", ra, 8'h05);
    chk("t1 wr latency", lat, 2);
    txn(1, 0, 8'h05, 8'h00, st, ra, rd, lat);
    chk("t1 rd status", st, 0);
    chk("t1 rd data", rd, 8'h10);
    chk("t1 rd latency", lat, 2);
    chk("t1 free_count", free_count, 255);

    // both ports hammering: grants must alternate 0,1,0,1
    @(negedge clk);
    a0 = 8'h20; a1 = 8'h30;
    req_write = 2'b11; req_wdata = 16'h3322;
    req_addr = {a1, a0}; req_valid = 2'b11;
    ng = 0; nr = 0; pend = 0; pport = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (pend) begin
        if (pport == 0) a0 = a0 + 8'h01; else a1 = a1 + 8'h01;
        req_addr = {a1, a0};
        pend = 0;
        if (ng == 4) req_valid = 2'b00;
      end
      #1;
      if (rsp_valid != 2'b00 && nr < 4) begin
        chk("alt rsp port", rsp_valid, 2'b01 << gseq[nr]);
        chk("alt rsp latency", cyc - gcyc[nr], 2);
        chk("alt rsp status", rsp_status, 0);
        nr++;
      end
      if (req_ready != 2'b00 && ng < 4) begin
        gseq[ng] = req_ready[1] ? 1 : 0;
        gcyc[ng] = cyc;
        pport = gseq[ng];
        ng++;
        pend = 1;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("alt grants", ng, 4);
    chk("alt responses", nr, 4);
    chk("alt order", {gseq[0][1:0], gseq[1][1:0], gseq[2][1:0], gseq[3][1:0]}, 8'b00_01_00_01);
    chk("alt free_count", free_count, 251);

    // write-once conflict
    txn(0, 1, 8'h10, 8'hAA, st, ra, rd, lat);
    chk("t3 first wr", st, 0);
    txn(0, 1, 8'h11, 8'h77, st, ra, rd, lat);
    txn(1, 1, 8'h10, 8'hBB, st, ra, rd, lat);
`ifdef RAM_REDIRECT_EN
    chk("t3 conflict status", st, 2'b01);
    chk("t3 conflict addr", ra, 8'h12);
    chk("t3 conflict latency", lat, 4);
    txn(0, 0, 8'h12, 8'h00, st, ra, rd, lat);
    chk("t3 redirected data", rd, 8'hBB);
    chk("t3 redirected status", st, 0);
`else
    chk("t3 conflict status", st, 2'b10);
    chk("t3 conflict addr", ra, 8'h10);
    txn(0, 0, 8'h12, 8'h00, st, ra, rd, lat);
    chk("t3 0x12 still free", st, 2'b11);
`endif
    txn(1, 0, 8'h10, 8'h00, st, ra, rd, lat);
    chk("t3 original data", rd, 8'hAA);

    // empty read, then clear_all blocking a request
    txn(0, 0, 8'h40, 8'h00, st, ra, rd, lat);
    chk("t5 empty status", st, 2'b11);
    chk("t5 empty data", rd, 0);
    @(negedge clk);
    clear_all = 1'b1; req_valid[0] = 1'b1; req_write[0] = 1'b0;
    #1 chk("t5 ready during clear", req_ready, 0);
    @(negedge clk);
    clear_all = 1'b0; req_valid[0] = 1'b0;
    chk("t5 free after clear", free_count, 256);
    chk("t5 full after clear", full, 0);

    // fill 0x00..0xFE, then hit the last region
    for (int a = 0; a < 255; a++) txn(a & 1, 1, 8'(a), 8'(a) ^ 8'h5A, st, ra, rd, lat);
    chk("t4 free one left", free_count, 1);
    txn(0, 1, 8'hFE, 8'hC3, st, ra, rd, lat);
`ifdef RAM_REDIRECT_EN
    chk("t4 wrap status", st, 2'b01);
    chk("t4 wrap addr", ra, 8'hFF);
    chk("t4 full", full, 1);
    chk("t4 free zero", free_count, 0);
`else
    chk("t4 conflict status", st, 2'b10);
    chk("t4 conflict addr", ra, 8'hFE);
    chk("t4 not full", full, 0);
    chk("t4 free one", free_count, 1);
`endif
    txn(1, 1, 8'h00, 8'h11, st, ra, rd, lat);
    chk("t4 reject status", st, 2'b10);
    chk("t4 reject addr", ra, 8'h00);
    txn(0, 0, 8'h00, 8'h00, st, ra, rd, lat);
    chk("t4 data kept", rd, 8'h5A);

    // reset mid-transaction
    do_clear();
`ifdef RAM_REDIRECT_EN
    txn(0, 1, 8'h50, 8'h01, st, ra, rd, lat);
    txn(0, 1, 8'h51, 8'h02, st, ra, rd, lat);
    tgt = 8'h50;
`else
    tgt = 8'h52;
`endif
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1;
    req_addr[7:0] = tgt; req_wdata[7:0] = 8'h99;
    #1 chk("t6 ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
`ifdef RAM_REDIRECT_EN
    @(negedge clk);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    quiet = 1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid != 2'b00) quiet = 0;
      @(negedge clk);
    end
    chk("t6 no response", quiet, 1);
    chk("t6 free_count", free_count, 256);
    txn(0, 0, 8'h52, 8'h00, st, ra, rd, lat);
    chk("t6 target free", st, 2'b11);
    txn(1, 1, 8'h52, 8'h33, st, ra, rd, lat);
    chk("t6 write after rst", st, 0);
    chk("t6 latency after rst", lat, 2);
    txn(0, 0, 8'h52, 8'h00, st, ra, rd, lat);
    chk("t6 readback", rd, 8'h33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/shared_ram_arbiter.md
Name: shared_ram_arbiter

Overview:
- Parametrised successor to the team's dual-port write-once RAM.
- NUM_PORTS requesters share one DEPTH x DATA_WIDTH memory on a single clock.
- Requesters use valid/ready handshakes and are served one at a time under round-robin arbitration.
- Per-location used flags enforce write-once semantics, and a conflicting write can be redirected to the next free address with wrap-around.

Parameters:
- ADDR_WIDTH, 8, address bits.
- DATA_WIDTH, 8, data bits.
- DEPTH, 1<<ADDR_WIDTH, number of locations (power of two required).
- NUM_PORTS, 2, requester count (1..8).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port accept. Combinational, one-hot or zero.
- req_write  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  packed request addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_PORTS*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_PORTS  one-cycle response strobe for the served port.
- rsp_data  out  DATA_WIDTH  read data, shared across ports.
- rsp_addr  out  ADDR_WIDTH  address actually accessed.
- rsp_status  out  2  00 OK, 01 REDIRECTED, 10 REJECTED, 11 EMPTY (read of a free location).
- clear_all  in  1  clear all used flags.
- free_count  out  ADDR_WIDTH+1  number of free locations.
- full  out  1  high when free_count==0.

Behaviour:
- Reset (async):
  - state=IDLE; used flags all 0; free_count=DEPTH; rr pointer=NUM_PORTS-1, so port 0 wins first.
  - rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_status=0, full=0.
  - Memory array is not reset.
  - Reset mid-transaction aborts it: no write, no response.
- FSM states are IDLE, ACCESS, SCAN, RESP.
- IDLE:
  - If clear_all=1: req_ready=0, all flags cleared, free_count=DEPTH, stay in IDLE.
  - Otherwise grant the first valid port starting at rr+1 (mod NUM_PORTS). Drive req_ready[g]=1.
  - On the handshake edge, capture write, addr, wdata and g; set rr=g; go to ACCESS.
  - clear_all outside IDLE is ignored.
- ACCESS, read: data = used[addr] ? mem[addr] : 0. Status OK, or EMPTY if the location is free. Go to RESP.
- ACCESS, write to a free addr: mem[addr]=wdata, used[addr]=1, free_count-1, status OK. Go to RESP.
- ACCESS, write to a used addr:
  - If full: status REJECTED, no write.
  - Otherwise (RAM_REDIRECT_EN): scan_addr=addr+1 (wraps mod DEPTH), go to SCAN.
- SCAN:
  - One location checked per cycle.
  - First free scan_addr: write there, used=1, free_count-1, rsp_addr=scan_addr, status REDIRECTED, go to RESP.
  - Otherwise scan_addr+1 with wrap-around.
  - Termination is guaranteed because free_count>0. Worst case DEPTH-1 cycles.
- RESP: rsp_valid[g]=1 for exactly one cycle with rsp_data/addr/status valid. Go to IDLE.
- Response outputs are registered and hold their last values between responses.
- Latency: accept edge T0. Response visible in the cycle after T1 for a direct access, or after T1+k for k scan steps.
- Throughput: one transaction per 3 cycles without redirect.
- free_count never underflows. full is derived combinationally from free_count.

Optional Feature:
- Macro: RAM_REDIRECT_EN.
- Defined: SCAN state present; a write to a used, non-full location is redirected as above.
- Undefined: no SCAN state. A write to any used location returns REJECTED with rsp_addr=requested addr; memory and flags are unchanged.

Test Plan:
- Reset, then port0 writes 0x10 to 0x05 and port1 reads 0x05 -> port0 rsp OK addr 0x05; port1 rsp OK data 0x10; free_count=255.
- Both ports valid every cycle with writes to distinct addrs -> grants alternate 0,1,0,1; each response arrives 2 cycles after its accept edge.
- Write 0xAA to 0x10, then write 0xBB to 0x10 (redirect on), with 0x11 used -> second rsp REDIRECTED addr 0x12; mem[0x12]=0xBB; mem[0x10]=0xAA.
- Fill 0x00..0xFE, then write to 0xFE (redirect on) -> wraps to 0xFF, REDIRECTED; full=1. A following write -> REJECTED; free_count=0.
- Read of a free address 0x40 -> rsp_data=0, status EMPTY. Then clear_all in IDLE -> free_count=256, full=0, req_ready held 0 that cycle.
- Assert rst during SCAN -> no rsp_valid, target location remains free, state IDLE; next request is served normally.
